// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite constants and types for the RAM arbiter slice.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  typedef enum logic [1:0] {PS_IDLE, PS_WAIT, PS_DATA} arb_port_state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } ahb_ctrl_t;
endpackage

// File: rtl/ahb_arb_port.sv
// ahb_arb_port: one slave-facing port of the arbiter; tracks its transfer state,
// buffers a losing address phase and gates HREADYOUT/HRDATA.
module ahb_arb_port
  import ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        hsel,
  input  logic        hready,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic        arb_en,
  input  logic        grant,
  input  logic        m_hreadyout,
  input  logic [31:0] m_hrdata,
  output logic        req,
  output logic        in_data,
  output ahb_ctrl_t   ctrl,
  output logic        hreadyout,
  output logic [31:0] hrdata
);
  arb_port_state_t state_q, state_d;
  ahb_ctrl_t       buf_q, buf_d, live_ctrl;
  logic            live;
  always_comb begin
    live      = hsel & hready & (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    live_ctrl = {haddr, hwrite, hsize};
    req       = (state_q == PS_WAIT) | live;
    ctrl      = (state_q == PS_WAIT) ? buf_q : live_ctrl;
    buf_d     = (live && state_q != PS_WAIT) ? live_ctrl : buf_q;
    // a live request is parked when it loses, or when the RAM is stalled and we were idle
    state_d   = grant ? PS_DATA :
                (live && (arb_en || state_q == PS_IDLE)) ? PS_WAIT :
                (state_q == PS_DATA && m_hreadyout) ? PS_IDLE : state_q;
    in_data   = state_q == PS_DATA;
    hreadyout = (state_q == PS_WAIT) ? 1'b0 : in_data ? m_hreadyout : 1'b1;
    hrdata    = in_data ? m_hrdata : '0;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= PS_IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end
endmodule

// File: rtl/ahb_ram_arbiter.sv
// ahb_ram_arbiter: two AHB-Lite masters sharing one zero-wait RAM; uncontested
// requests pass straight through, a loser is buffered and stalled.
module ahb_ram_arbiter
  import ahb_pkg::*;
#(
  parameter int RR_ARB = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        S0_HSEL,
  input  logic        S0_HREADY,
  input  logic        S0_HWRITE,
  input  logic [31:0] S0_HADDR,
  input  logic [1:0]  S0_HTRANS,
  input  logic [2:0]  S0_HSIZE,
  input  logic [31:0] S0_HWDATA,
  output logic        S0_HREADYOUT,
  output logic [31:0] S0_HRDATA,
  input  logic        S1_HSEL,
  input  logic        S1_HREADY,
  input  logic        S1_HWRITE,
  input  logic [31:0] S1_HADDR,
  input  logic [1:0]  S1_HTRANS,
  input  logic [2:0]  S1_HSIZE,
  input  logic [31:0] S1_HWDATA,
  output logic        S1_HREADYOUT,
  output logic [31:0] S1_HRDATA,
  output logic        M_HSEL,
  output logic        M_HREADY,
  output logic        M_HWRITE,
  output logic [31:0] M_HADDR,
  output logic [1:0]  M_HTRANS,
  output logic [2:0]  M_HSIZE,
  output logic [31:0] M_HWDATA,
  input  logic        M_HREADYOUT,
  input  logic [31:0] M_HRDATA
);
  logic      arb_en, r0, r1, d0, d1, g0, g1, last_grant_q, last_grant_d;
  ahb_ctrl_t c0, c1, mc;
  ahb_arb_port u_p0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .hsel(S0_HSEL), .hready(S0_HREADY), .htrans(S0_HTRANS),
    .haddr(S0_HADDR), .hwrite(S0_HWRITE), .hsize(S0_HSIZE), .arb_en(arb_en), .grant(g0),
    .m_hreadyout(M_HREADYOUT), .m_hrdata(M_HRDATA), .req(r0), .in_data(d0), .ctrl(c0),
    .hreadyout(S0_HREADYOUT), .hrdata(S0_HRDATA)
  );
  ahb_arb_port u_p1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .hsel(S1_HSEL), .hready(S1_HREADY), .htrans(S1_HTRANS),
    .haddr(S1_HADDR), .hwrite(S1_HWRITE), .hsize(S1_HSIZE), .arb_en(arb_en), .grant(g1),
    .m_hreadyout(M_HREADYOUT), .m_hrdata(M_HRDATA), .req(r1), .in_data(d1), .ctrl(c1),
    .hreadyout(S1_HREADYOUT), .hrdata(S1_HRDATA)
  );
  always_comb begin
    arb_en       = ~(d0 | d1) | M_HREADYOUT;
    // last_grant=1 means port 0 is favoured next under round-robin
    g0           = arb_en & r0 & (~r1 | (RR_ARB == 0) | last_grant_q);
    g1           = arb_en & r1 & ~g0;
    last_grant_d = g1 ? 1'b1 : g0 ? 1'b0 : last_grant_q;
    mc           = g0 ? c0 : g1 ? c1 : '0;
    M_HSEL       = g0 | g1;
    M_HTRANS     = M_HSEL ? HTRANS_NONSEQ : HTRANS_IDLE;
    M_HADDR      = mc.addr;
    M_HWRITE     = mc.write;
    M_HSIZE      = mc.size;
    M_HREADY     = M_HREADYOUT;
    M_HWDATA     = d0 ? S0_HWDATA : d1 ? S1_HWDATA : '0;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) last_grant_q <= 1'b1;
    else last_grant_q <= last_grant_d;
  end
endmodule

// File: doc/ahb_ram_arbiter.md
Name: ahb_ram_arbiter

Overview:
Two-master AHB-Lite arbiter placed in front of the single-port, zero-wait ahb_ram slave, so the CPU (port 0) and a second master (port 1, DMA/display) share one RAM. Each port looks like an AHB-Lite slave. An uncontested request passes straight through with no added latency. A losing address phase is captured in a per-port buffer, and that port is stalled with HREADYOUT low until its transfer completes downstream.

Parameters:
RR_ARB, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins (port 1 may starve).

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
S0_HSEL, S0_HREADY, S0_HWRITE  in  1 each  port 0 select, bus ready, write
S0_HADDR  in  32  port 0 address
S0_HTRANS  in  2  port 0 transfer type
S0_HSIZE  in  3  port 0 size
S0_HWDATA  in  32  port 0 write data
S0_HREADYOUT  out  1  port 0 ready response
S0_HRDATA  out  32  port 0 read data
S1_*  same set as S0_*  port 1
M_HSEL, M_HREADY, M_HWRITE  out  1 each  to RAM
M_HADDR  out  32  to RAM
M_HTRANS  out  2  to RAM
M_HSIZE  out  3  to RAM
M_HWDATA  out  32  to RAM
M_HREADYOUT  in  1  from RAM
M_HRDATA  in  32  from RAM

Behaviour:
- Reset: HCLK clock, HRESETn asynchronous active-low. Reset clears both port states to IDLE, clears buffers, sets last_grant=1 (port 0 favoured first), sets owner=none. Reset is honoured mid-transfer; all in-flight and buffered requests are discarded.
- Live request on port i: Si_HSEL & Si_HREADY & Si_HTRANS[1]. IDLE (00) and BUSY (01) are not requests.
- Per-port state:
  - IDLE: nothing outstanding.
  - WAIT: address phase captured (HADDR, HWRITE, HSIZE), not yet issued.
  - DATA: issued; port is in its RAM data phase.
- Si_HREADYOUT: WAIT -> 0; DATA -> M_HREADYOUT; IDLE -> 1.
- Arbitration runs in any cycle where owner=none or M_HREADYOUT=1.
  - Candidates: ports in WAIT, plus live requests from ports in IDLE or DATA.
  - One candidate: it wins.
  - Two candidates: RR_ARB=1 picks the port != last_grant; RR_ARB=0 picks port 0.
  - Winner's address and control drive M_* combinationally in the same cycle, from the buffer (WAIT) or from the live inputs. Winner goes to DATA next cycle and last_grant updates.
  - A losing live request is captured and its port goes to WAIT next cycle.
- No candidate: M_HSEL=0, M_HTRANS=00, and M_HADDR/M_HWRITE/M_HSIZE driven 0.
- Issued transfers: M_HSEL=1 and M_HTRANS=NONSEQ (10) always. SEQ is rewritten because bursts may be broken.
- M_HREADY = M_HREADYOUT.
- If arbitration is blocked (M_HREADYOUT=0), a live request from a non-owner IDLE port is captured into WAIT.
- The DATA port leaves to IDLE when M_HREADYOUT=1, unless it is re-granted a new live request that cycle, in which case it stays in DATA.
- Data phase routing:
  - M_HWDATA = HWDATA of the DATA-state port, or 0 if none. A stalled master holds HWDATA stable per AHB, so no write-data buffer is needed.
  - Si_HRDATA = M_HRDATA when port i is in DATA, else 0.
- Latency: uncontested transfers add 0 cycles. A contested loser adds 1 cycle per transfer granted ahead of it. With RR_ARB=1, the worst case is 1 extra cycle.
- At most one port in DATA; at most one outstanding request per port. No HMASTLOCK support.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS constants: HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ.
  - Enum arb_port_state_t {PS_IDLE, PS_WAIT, PS_DATA}.
  - Typedef ahb_ctrl_t {addr[31:0], write, size[2:0]}.
- Sub-module ahb_arb_port, instantiated twice. It holds the state register, capture buffer, request detection, HREADYOUT generation and read-data gating.
- Top level holds last_grant, the grant logic and the M_* muxes.

Test Plan:
- Port 0 write word 0x000 = 0xDEADBEEF, port 1 idle -> M_HADDR=0x000 in the same cycle, S0_HREADYOUT=1 throughout; port 0 then reads 0x000 and gets 0xDEADBEEF next cycle.
- Both ports request in cycle N (S0 read 0x004, S1 read 0x008), RR after reset:
  - Port 0 issued in cycle N.
  - S1_HREADYOUT=0 in N+1 while port 1 is issued in N+1.
  - S1_HRDATA valid in N+2.
  - S0_HRDATA valid in N+1.
- Continuous back-to-back requests from both ports for 20 cycles, RR_ARB=1 -> grants strictly alternate; neither HREADYOUT is low for 2 consecutive cycles.
- Same stimulus with RR_ARB=0 -> port 0 granted every cycle; port 1 held in WAIT with S1_HREADYOUT=0 until port 0 goes idle.
- Contested byte write from port 1 (HSIZE=0, addr 0x00D, HWDATA=0x0000AB00) while port 0 wins -> HWDATA held through the stall; a later word read of 0x00C shows 0x0000AB00 in byte 1 only.
- HRESETn asserted while port 1 is in WAIT -> both HREADYOUT=1 and M_HTRANS=00 immediately; after release, first contested grant goes to port 0.
